// File: rtl/div_iter_pkg.sv
// Shared execute-stage definitions: data type, divider FSM states and default iteration count.
package cpuDefine;

  localparam int DIV_ITERS = 32;

  typedef logic [DIV_ITERS-1:0] DType;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX
  } DivState;

endpackage

// File: rtl/div_clz.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
module div_clz #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]        data,
  output logic [$clog2(WIDTH):0]  count
);

  // seen_one[i] is set when any bit at or above position i is one
  logic [WIDTH-1:0] seen_one;

  assign seen_one[WIDTH-1] = data[WIDTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_or_chain
      assign seen_one[gi] = data[gi] | seen_one[gi+1];
    end
  endgenerate

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + {{$clog2(WIDTH){1'b0}}, ~seen_one[i]};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) with flush support.
// Optional DIV_EARLY_OUT_EN: pre-normalise the dividend to shorten the iteration count.
module div_iter
  import cpuDefine::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             complete,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  DivState          state_reg, state_next;
  logic [WIDTH-1:0] rem_reg, quo_reg, dsr_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic [CW-1:0]    cnt_reg;
  logic             q_neg_reg, r_neg_reg, div0_reg, complete_reg;
  logic             load, step_en, finish;

  logic             a_neg, b_neg, div0;
  logic [WIDTH-1:0] a_abs, b_abs, quo_init, rem_init;
  logic [CW-1:0]    cnt_init;

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign a_abs = a_neg ? -dividend : dividend;
  assign b_abs = b_neg ? -divisor : divisor;
  assign div0  = (divisor == '0);

`ifdef DIV_EARLY_OUT_EN
  logic [CW-1:0] clz;
  logic          skip, skip_reg;

  div_clz #(.WIDTH(WIDTH)) u_clz (
    .data  (a_abs),
    .count (clz)
  );

  assign skip = div0 | (a_abs == '0);

  // Trivial operands park their final magnitudes and spend one idle CALC cycle
  always_comb begin
    quo_init = a_abs << clz;
    rem_init = '0;
    cnt_init = CW'(WIDTH) - clz;
    if (skip) begin
      quo_init = div0 ? '1 : '0;
      rem_init = div0 ? a_abs : '0;
      cnt_init = CW'(1);
    end
  end
`else
  assign quo_init = a_abs;
  assign rem_init = '0;
  assign cnt_init = CW'(WIDTH);
`endif

  // One restoring step: shift {rem,quo} left, trial-subtract, keep on no borrow
  logic [WIDTH:0]   rem_shift, trial;
  logic             fits;
  logic [WIDTH-1:0] rem_step, quo_step, quo_mag, rem_mag, q_fix, r_fix;

  assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dsr_reg};
  assign fits      = ~trial[WIDTH];
  assign rem_step  = fits ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_step  = {quo_reg[WIDTH-2:0], fits};

`ifdef DIV_EARLY_OUT_EN
  assign quo_mag = skip_reg ? quo_reg : quo_step;
  assign rem_mag = skip_reg ? rem_reg : rem_step;
`else
  assign quo_mag = quo_step;
  assign rem_mag = rem_step;
`endif

  // Divide-by-zero keeps an all-ones quotient regardless of operand signs
  assign q_fix = div0_reg ? '1 : (q_neg_reg ? -quo_mag : quo_mag);
  assign r_fix = r_neg_reg ? -rem_mag : rem_mag;

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step_en    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      DIV_IDLE: begin
        if (en) begin
          load       = 1'b1;
          state_next = DIV_CALC;
        end
      end
      DIV_CALC: begin
        step_en = 1'b1;
        if (cnt_reg == CW'(1)) begin
          finish     = 1'b1;
          state_next = DIV_FIX;
        end
      end
      DIV_FIX:  state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
    if (flush) begin
      state_next = DIV_IDLE;
      load       = 1'b0;
      step_en    = 1'b0;
      finish     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= DIV_IDLE;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dsr_reg       <= '0;
      cnt_reg       <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      div0_reg      <= 1'b0;
      complete_reg  <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
`ifdef DIV_EARLY_OUT_EN
      skip_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      complete_reg <= finish;
      if (load) begin
        rem_reg   <= rem_init;
        quo_reg   <= quo_init;
        dsr_reg   <= b_abs;
        cnt_reg   <= cnt_init;
        q_neg_reg <= a_neg ^ b_neg;
        r_neg_reg <= a_neg;
        div0_reg  <= div0;
`ifdef DIV_EARLY_OUT_EN
        skip_reg  <= skip;
`endif
      end else if (step_en) begin
        rem_reg <= rem_step;
        quo_reg <= quo_step;
        cnt_reg <= cnt_reg - CW'(1);
      end
      if (finish) begin
        quotient_reg  <= q_fix;
        remainder_reg <= r_fix;
      end
    end
  end

  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign complete  = complete_reg;
  assign busy      = (state_reg != DIV_IDLE);

endmodule
